// File: rtl/x2050_pkg.sv
// Shared definitions for the storage-store path: sequencer state encoding,
// byte-stat width and the BS-to-byte-lane mapping used by the BS register block.
package x2050_pkg;

    localparam int BS_W   = 4;
    localparam int BYTE_W = 8;
    localparam int WORD_W = BS_W * BYTE_W;

    localparam logic [BS_W-1:0] BS_FULL = '1;
    localparam logic [BS_W-1:0] BS_NONE = '0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_DONE = 2'd3
    } store_state_t;

    // Mark bit (3-n) owns byte n, and byte 0 is the most significant byte.
    function automatic logic [WORD_W-1:0] bs_lane_mask(input logic [BS_W-1:0] bs);
        logic [WORD_W-1:0] m;
        m = '0;
        for (int n = 0; n < BS_W; n++)
            m[WORD_W-1-BYTE_W*n -: BYTE_W] = {BYTE_W{bs[BS_W-1-n]}};
        return m;
    endfunction

    // BS pattern for a single-byte store at storage byte address b.
    function automatic logic [BS_W-1:0] bs_for_byte(input logic [1:0] b);
        logic [BS_W-1:0] one_hot;
        one_hot = {1'b1, {(BS_W-1){1'b0}}};
        return one_hot >> b;
    endfunction

endpackage

// File: rtl/x2050_byte_merge.sv
// Byte-lane merge: each lane comes from new_word where its mark is set,
// otherwise from old_word.
module x2050_byte_merge
    import x2050_pkg::*;
(
    input  logic [WORD_W-1:0] new_word,
    input  logic [WORD_W-1:0] old_word,
    input  logic [BS_W-1:0]   marks,
    output logic [WORD_W-1:0] merged
);

    logic [WORD_W-1:0] lane_mask;

    assign lane_mask = bs_lane_mask(marks);
    assign merged    = (new_word & lane_mask) | (old_word & ~lane_mask);

endmodule

// File: rtl/x2050_mark_store.sv
// Storage-store sequencer: full marks write directly, partial marks do a
// read-modify-write, zero marks complete without a storage cycle.
module x2050_mark_store
    import x2050_pkg::*;
#(
    parameter int ADDR_W = 17
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_store,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [WORD_W-1:0] i_data,
    input  logic [BS_W-1:0]   i_bs,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [WORD_W-1:0] o_mem_wdata,
    input  logic              i_mem_ack,
    input  logic [WORD_W-1:0] i_mem_rdata
);

    store_state_t      state, state_n;
    logic [WORD_W-1:0] data_q, data_n;
    logic [BS_W-1:0]   marks_q, marks_n;
    logic              busy_n, done_n, req_n, we_n;
    logic [ADDR_W-1:0] addr_n;
    logic [WORD_W-1:0] wdata_n;
    logic [WORD_W-1:0] merged;

    x2050_byte_merge u_merge (
        .new_word (data_q),
        .old_word (i_mem_rdata),
        .marks    (marks_q),
        .merged   (merged)
    );

    // Outputs are registered from the next-state values so req rises the
    // cycle after accept; o_done trails the DONE state by one cycle.
    always_comb begin
        state_n = state;
        data_n  = data_q;
        marks_n = marks_q;
        busy_n  = o_busy;
        done_n  = (state == ST_DONE);
        req_n   = 1'b0;
        we_n    = 1'b0;
        addr_n  = o_mem_addr;
        wdata_n = o_mem_wdata;

        if (o_done)
            busy_n = 1'b0;

        case (state)
            ST_IDLE: begin
                if (i_store && !o_busy) begin
                    data_n  = i_data;
                    marks_n = i_bs;
                    addr_n  = i_addr;
                    busy_n  = 1'b1;
                    if (i_bs == BS_FULL) begin
                        state_n = ST_WR;
                        req_n   = 1'b1;
                        we_n    = 1'b1;
                        wdata_n = i_data;
                    end else if (i_bs == BS_NONE) begin
                        state_n = ST_DONE;
                    end else begin
                        state_n = ST_RD;
                        req_n   = 1'b1;
                    end
                end
            end
            ST_RD: begin
                req_n = 1'b1;
                if (i_mem_ack) begin
                    state_n = ST_WR;
                    we_n    = 1'b1;
                    wdata_n = merged;
                end
            end
            ST_WR: begin
                if (i_mem_ack) begin
                    state_n = ST_DONE;
                end else begin
                    req_n = 1'b1;
                    we_n  = 1'b1;
                end
            end
            ST_DONE: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state       <= ST_IDLE;
            data_q      <= '0;
            marks_q     <= '0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_mem_req   <= 1'b0;
            o_mem_we    <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
        end else begin
            state       <= state_n;
            data_q      <= data_n;
            marks_q     <= marks_n;
            o_busy      <= busy_n;
            o_done      <= done_n;
            o_mem_req   <= req_n;
            o_mem_we    <= we_n;
            o_mem_addr  <= addr_n;
            o_mem_wdata <= wdata_n;
        end
    end

endmodule

// File: tb/tb_x2050_mark_store.sv
// Bench for x2050_mark_store: transaction-level model of expected storage
// cycles and completion timing, checked against the DUT every cycle.
module tb_x2050_mark_store;

    localparam int AW = 17;

    logic          clk = 1'b0;
    logic          reset, store, busy, done, req, we, ack;
    logic [AW-1:0] addr, maddr;
    logic [31:0]   data, wdata, rdata;
    logic [3:0]    bs;

    always #5 clk = ~clk;

    x2050_mark_store #(.ADDR_W(AW)) dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_store     (store),
        .i_addr      (addr),
        .i_data      (data),
        .i_bs        (bs),
        .o_busy      (busy),
        .o_done      (done),
        .o_mem_req   (req),
        .o_mem_we    (we),
        .o_mem_addr  (maddr),
        .o_mem_wdata (wdata),
        .i_mem_ack   (ack),
        .i_mem_rdata (rdata)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic          we;
        logic [AW-1:0] a;
        logic [31:0]   d;
    } mcyc_t;

    mcyc_t       expq[$];
    int          dq[$];
    logic [31:0] rq[$];
    int          exp_start = 0;
    int          exp_done = -1;
    bit          chk_en = 0;
    int          c0 = 0;
    int          last_done = -1;
    logic [31:0] last_wr = '0;
    int          n_rd = 0, n_wr = 0, n_req = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] model_merge(input logic [31:0] nw, input logic [31:0] ow,
                                                input logic [3:0] m);
        logic [31:0] r;
        for (int n = 0; n < 4; n++)
            r[31-8*n -: 8] = m[3-n] ? nw[31-8*n -: 8] : ow[31-8*n -: 8];
        return r;
    endfunction

    // Memory responder: acks each storage cycle after its scheduled delay,
    // and throws spurious acks when no request is pending.
    initial begin : responder
        int cnt;
        cnt = 0;
        forever begin
            @(negedge clk); #1;
            rdata = $urandom;
            if (req) begin
                if (dq.size() > 0 && cnt >= dq[0]) begin
                    ack = 1'b1;
                    rdata = rq[0];
                    void'(dq.pop_front());
                    void'(rq.pop_front());
                    cnt = 0;
                end else begin
                    ack = 1'b0;
                    cnt++;
                end
            end else begin
                ack = ($urandom_range(3) == 0);
                cnt = 0;
            end
        end
    end

    // Per-cycle compare against the transaction model.
    initial begin : compare
        logic        last_req, last_we;
        logic [31:0] last_wd;
        last_req = 1'b0; last_we = 1'b0; last_wd = '0;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                if (last_req && ack && expq.size() > 0) begin
                    if (last_we) begin n_wr++; last_wr = last_wd; end
                    else n_rd++;
                    void'(expq.pop_front());
                end
                chk("busy", 64'(busy), 64'(cyc >= exp_start && cyc <= exp_done));
                chk("done", 64'(done), 64'(cyc == exp_done));
                chk("req", 64'(req), 64'(expq.size() > 0));
                if (req && expq.size() > 0) begin
                    chk("we", 64'(we), 64'(expq[0].we));
                    chk("addr", 64'(maddr), 64'(expq[0].a));
                    if (expq[0].we) chk("wdata", 64'(wdata), 64'(expq[0].d));
                end
                if (req) n_req++;
                if (done) last_done = cyc;
            end
            last_req = req; last_we = we; last_wd = wdata;
        end
    end

    task automatic start_txn(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] m,
                             input logic [31:0] rd, input int d1, input int d2);
        c0 = cyc;
        addr = a; data = d; bs = m; store = 1'b1;
        if (m == 4'hF) begin
            expq.push_back('{1'b1, a, d});
            dq.push_back(d1); rq.push_back(32'h0);
            exp_done = c0 + d1 + 3;
        end else if (m == 4'h0) begin
            exp_done = c0 + 2;
        end else begin
            expq.push_back('{1'b0, a, 32'h0});
            dq.push_back(d1); rq.push_back(rd);
            expq.push_back('{1'b1, a, model_merge(d, rd, m)});
            dq.push_back(d2); rq.push_back(32'h0);
            exp_done = c0 + d1 + d2 + 4;
        end
        exp_start = c0 + 1;
        @(negedge clk); #1;
        store = 1'b0; addr = AW'($urandom); data = $urandom; bs = 4'($urandom);
    endtask

    task automatic wait_idle(input bit pulse_done, input bit pulse_rand);
        int k;
        k = 0;
        while (busy && k < 400) begin
            if ((pulse_done && cyc == exp_done) || (pulse_rand && $urandom_range(3) == 0)) begin
                store = 1'b1; addr = AW'($urandom); data = $urandom; bs = 4'($urandom);
            end else begin
                store = 1'b0;
            end
            @(negedge clk); #1;
            k++;
        end
        store = 1'b0;
        if (busy) begin
            tests++; fails++;
            $display("FAIL idle_timeout at cycle %0d: busy still 1 after %0d cycles", cyc, k);
        end
    endtask

    task automatic clr_counts();
        n_rd = 0; n_wr = 0; n_req = 0;
    endtask

    initial begin : driver
        reset = 1'b1; store = 1'b0; addr = '0; data = '0; bs = '0;
        ack = 1'b0; rdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_req", 64'(req), 64'd0);
        chk("rst_we", 64'(we), 64'd0);
        chk("rst_addr", 64'(maddr), 64'd0);
        chk("rst_wdata", 64'(wdata), 64'd0);
        #1 reset = 1'b0;
        chk_en = 1;
        @(negedge clk); #1;

        // Model pinned to hand-computed merges.
        chk("model_pin_a", 64'(model_merge(32'h11223344, 32'hAABBCCDD, 4'b0100)), 64'hAA22CCDD);
        chk("model_pin_b", 64'(model_merge(32'h000000FF, 32'h12345678, 4'b0001)), 64'h123456FF);

        // Full marks, ack on the second request cycle.
        clr_counts();
        start_txn(17'h00123, 32'hDEADBEEF, 4'hF, 32'h0, 1, 0);
        wait_idle(0, 0);
        chk("full_wdata", 64'(last_wr), 64'hDEADBEEF);
        chk("full_latency", 64'(last_done - c0), 64'd4);
        chk("full_reads", 64'(n_rd), 64'd0);
        chk("full_writes", 64'(n_wr), 64'd1);

        // Partial marks, same-cycle ack on both storage cycles.
        clr_counts();
        start_txn(17'h00456, 32'h11223344, 4'b0100, 32'hAABBCCDD, 0, 0);
        wait_idle(0, 0);
        chk("part_wdata", 64'(last_wr), 64'hAA22CCDD);
        chk("part_latency", 64'(last_done - c0), 64'd4);
        chk("part_reads", 64'(n_rd), 64'd1);
        chk("part_writes", 64'(n_wr), 64'd1);

        // Zero marks: no storage cycle at all.
        clr_counts();
        start_txn(17'h00789, 32'hCAFEF00D, 4'h0, 32'h0, 0, 0);
        wait_idle(0, 0);
        chk("zero_latency", 64'(last_done - c0), 64'd2);
        chk("zero_req_cycles", 64'(n_req), 64'd0);

        // Long back-pressure with stray stores while busy and in the done cycle.
        clr_counts();
        start_txn(17'h0ABCD, 32'h55667788, 4'b1010, 32'h99AABBCC, 10, 10);
        wait_idle(1, 1);
        chk("bp_latency", 64'(last_done - c0), 64'd24);
        chk("bp_wdata", 64'(last_wr), 64'h55AA77CC);
        chk("bp_writes", 64'(n_wr), 64'd1);

        clr_counts();
        start_txn(17'h10000, 32'h01020304, 4'hF, 32'h0, 2, 0);
        wait_idle(1, 1);
        chk("ign_writes", 64'(n_wr), 64'd1);
        chk("ign_reads", 64'(n_rd), 64'd0);

        // Reset in the middle of a read cycle.
        start_txn(17'h01111, 32'hFFFFFFFF, 4'b0011, 32'h0, 30, 0);
        repeat (3) begin @(negedge clk); #1; end
        reset = 1'b1;
        expq.delete(); dq.delete(); rq.delete();
        exp_start = 0; exp_done = -1;
        @(negedge clk); #1;
        reset = 1'b0;
        chk("mrst_req", 64'(req), 64'd0);
        chk("mrst_busy", 64'(busy), 64'd0);
        chk("mrst_addr", 64'(maddr), 64'd0);
        chk("mrst_wdata", 64'(wdata), 64'd0);
        clr_counts();
        start_txn(17'h1FFFF, 32'h000000FF, 4'b0001, 32'h12345678, 2, 1);
        wait_idle(0, 0);
        chk("post_rst_wdata", 64'(last_wr), 64'h123456FF);
        chk("post_rst_latency", 64'(last_done - c0), 64'd7);

        // Randomized transactions.
        for (int t = 0; t < 150; t++) begin
            logic [3:0] m;
            int sel;
            sel = $urandom_range(3);
            m = (sel == 0) ? 4'hF : (sel == 1) ? 4'h0 : 4'($urandom);
            start_txn(AW'($urandom), $urandom, m, $urandom,
                      $urandom_range(4), $urandom_range(4));
            wait_idle($urandom_range(1) == 1, 1);
            repeat ($urandom_range(2)) begin @(negedge clk); #1; end
        end

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

endmodule
